// File: rtl/uart_transmitter.sv
// UART transmit path: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the parity bit (11-bit frame); default build sends 10-bit frames.
module uart_transmitter #(
  parameter int BAUD_RATE      = 9600,
  parameter int CLOCK_FREQ     = 50000000,
  parameter int CYCLES_PER_BIT = CLOCK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       Tx,
  output logic       busy,
  output logic       tx_done
);
  localparam int                CNT_W    = $clog2(CYCLES_PER_BIT) + 1;
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  DONE_AT  = CNT_W'(CYCLES_PER_BIT - 2);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] baud_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       hold_q;
  logic             hold_full_q;
  logic             data_ready_q;
  logic             tx_q;
  logic             busy_q;
  logic             tx_done_q;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  logic       bit_end;
  logic       stop_end;
  logic       accept;
  logic       load_hold;
  logic       load_direct;
  logic       to_hold;
  logic       hold_full_d;
  logic [7:0] load_byte;

  // A new frame starts from IDLE or straight out of the last stop cycle, so queued bytes leave no gap.
  always_comb begin
    bit_end     = (baud_q == BIT_LAST);
    stop_end    = (state_q == S_STOP) && bit_end;
    accept      = data_valid && data_ready_q;
    load_hold   = hold_full_q && ((state_q == S_IDLE) || stop_end);
    load_direct = accept && !hold_full_q && ((state_q == S_IDLE) || stop_end);
    to_hold     = accept && !load_direct;
    hold_full_d = (hold_full_q && !load_hold) || to_hold;
    load_byte   = load_hold ? hold_q : data_in;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      data_ready_q <= 1'b1;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q     <= 1'b0;
`endif
    end else if (!enable) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_cnt_q    <= '0;
      hold_full_q  <= 1'b0;
      data_ready_q <= 1'b1;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      tx_done_q    <= 1'b0;
    end else begin
      hold_full_q  <= hold_full_d;
      data_ready_q <= !hold_full_d;
      // Registered one cycle early so the pulse lines up with the final stop-bit cycle.
      tx_done_q    <= (state_q == S_STOP) && (baud_q == DONE_AT);
      if (to_hold) begin
        hold_q <= data_in;
      end

      if (load_hold || load_direct) begin
        state_q   <= S_START;
        shift_q   <= load_byte;
        baud_q    <= '0;
        bit_cnt_q <= '0;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
        parity_q  <= ^load_byte;
`endif
      end else if (state_q == S_IDLE) begin
        baud_q <= '0;
        tx_q   <= 1'b1;
        busy_q <= 1'b0;
      end else begin
        baud_q <= bit_end ? '0 : baud_q + CNT_ONE;
        if (bit_end) begin
          case (state_q)
            S_START: begin
              state_q <= S_DATA;
              tx_q    <= shift_q[0];
            end
            S_DATA: begin
              if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state_q <= S_PARITY;
                tx_q    <= parity_q;
`else
                state_q <= S_STOP;
                tx_q    <= 1'b1;
`endif
              end else begin
                shift_q   <= {1'b0, shift_q[7:1]};
                tx_q      <= shift_q[1];
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
              state_q <= S_STOP;
              tx_q    <= 1'b1;
            end
`endif
            S_STOP: begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
            default: begin
              state_q <= S_IDLE;
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign data_ready = data_ready_q;
  assign Tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = tx_done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter with CYCLES_PER_BIT = 10; expected line bits are queued per accepted byte.
module tb_uart_transmitter;
  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int N = FB * CPB;

  logic       clk        = 1'b0;
  logic       nRst       = 1'b1;
  logic       enable     = 1'b0;
  logic [7:0] data_in    = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready;
  logic       Tx;
  logic       busy;
  logic       tx_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit exp_q[$];
  logic tx_at   [0:255];
  logic done_at [0:255];
  logic busy_at [0:255];
  logic rdy_at  [0:255];

  uart_transmitter #(
    .BAUD_RATE (10),
    .CLOCK_FREQ(100)
  ) dut (
    .clk       (clk),
    .nRst      (nRst),
    .enable    (enable),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .Tx        (Tx),
    .busy      (busy),
    .tx_done   (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: still running at time %0t, limit 500000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (data_ready === 1'b1) ok = 1'b1;
    end
  endtask

  // Record outputs at the negedges numbered first..last after the accepting edge.
  task automatic observe(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      tx_at[i]   = Tx;
      done_at[i] = tx_done;
      busy_at[i] = busy;
      rdy_at[i]  = data_ready;
    end
  endtask

  task automatic test_power_on_reset();
    #1 nRst = 1'b0;
    #1;
    n_checks++; if (Tx !== 1'b1)         begin n_fail++; $display("FAIL por_tx: Tx=%b, required 1", Tx); end
    n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL por_ready: data_ready=%b, required 1", data_ready); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL por_busy: busy=%b, required 0", busy); end
    n_checks++; if (tx_done !== 1'b0)    begin n_fail++; $display("FAIL por_done: tx_done=%b, required 0", tx_done); end
    repeat (3) @(negedge clk);
    nRst   = 1'b1;
    enable = 1'b1;
    $display("test_power_on_reset done");
  endtask

  task automatic test_frame(input logic [7:0] b, input string tag);
    bit         ok;
    bit         exp_bit;
    logic [7:0] rx;
    int         ndone;
    wait_ready(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL %s ready_timeout: data_ready=%b, required 1", tag, data_ready); end
    data_in    = b;
    data_valid = 1'b1;
    push_frame(b);
    @(posedge clk);
    #1 data_valid = 1'b0;
    data_in = ~b;
    observe(1, N + 1);
    n_checks++; if (tx_at[1] !== 1'b0)  begin n_fail++; $display("FAIL %s start_latency: Tx=%b, required 0", tag, tx_at[1]); end
    n_checks++; if (tx_at[10] !== 1'b0) begin n_fail++; $display("FAIL %s start_len: Tx=%b, required 0", tag, tx_at[10]); end
    n_checks++; if (tx_at[11] !== b[0]) begin n_fail++; $display("FAIL %s first_data: Tx=%b, required %b", tag, tx_at[11], b[0]); end
    for (int k = 0; k < FB; k++) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL %s bit%0d: scoreboard empty, Tx=%b", tag, k, tx_at[k*CPB+5]);
      end else begin
        exp_bit = exp_q.pop_front();
        if (tx_at[k*CPB+5] !== exp_bit) begin
          n_fail++; $display("FAIL %s bit%0d: Tx=%b, required %b", tag, k, tx_at[k*CPB+5], exp_bit);
        end
      end
    end
    for (int i = 0; i < 8; i++) rx[i] = tx_at[(i+1)*CPB+5];
    n_checks++; if (rx !== b) begin n_fail++; $display("FAIL %s rx_data: got %h, required %h", tag, rx, b); end
`ifdef UART_TX_PARITY_EN
    n_checks++; if (tx_at[9*CPB+5] !== ^b) begin n_fail++; $display("FAIL %s parity: Tx=%b, required %b", tag, tx_at[9*CPB+5], ^b); end
`endif
    ndone = 0;
    for (int i = 1; i <= N + 1; i++) if (done_at[i] === 1'b1) ndone++;
    n_checks++; if (ndone != 1 || done_at[N] !== 1'b1) begin n_fail++; $display("FAIL %s tx_done: pulses=%0d at_end=%b, required 1 pulse at cycle %0d", tag, ndone, done_at[N], N); end
    n_checks++; if (busy_at[1] !== 1'b1 || busy_at[N] !== 1'b1 || busy_at[N+1] !== 1'b0) begin n_fail++; $display("FAIL %s busy: %b%b%b, required 110", tag, busy_at[1], busy_at[N], busy_at[N+1]); end
    n_checks++; if (tx_at[N+1] !== 1'b1) begin n_fail++; $display("FAIL %s idle_tx: Tx=%b, required 1", tag, tx_at[N+1]); end
    $display("test_frame %s byte=%h rx=%h tx_done_pulses=%0d", tag, b, rx, ndone);
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit exp_bit;
    int ndone;
    wait_ready(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b ready_timeout: data_ready=%b, required 1", data_ready); end
    data_in    = 8'h3C;
    data_valid = 1'b1;
    push_frame(8'h3C);
    @(posedge clk);
    #1 data_in = 8'hC3;
    push_frame(8'hC3);
    @(posedge clk);
    #1 data_valid = 1'b0;
    observe(2, 2*N + 1);
    n_checks++; if (rdy_at[2] !== 1'b0)   begin n_fail++; $display("FAIL b2b hold_ready: data_ready=%b, required 0", rdy_at[2]); end
    n_checks++; if (rdy_at[N] !== 1'b0)   begin n_fail++; $display("FAIL b2b ready_stop: data_ready=%b, required 0", rdy_at[N]); end
    n_checks++; if (rdy_at[N+1] !== 1'b1) begin n_fail++; $display("FAIL b2b ready_rise: data_ready=%b, required 1", rdy_at[N+1]); end
    n_checks++; if (tx_at[N+1] !== 1'b0)  begin n_fail++; $display("FAIL b2b no_gap: Tx=%b, required 0", tx_at[N+1]); end
    for (int k = 0; k < 2*FB; k++) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++; $display("FAIL b2b bit%0d: scoreboard empty, Tx=%b", k, tx_at[k*CPB+5]);
      end else begin
        exp_bit = exp_q.pop_front();
        if (tx_at[k*CPB+5] !== exp_bit) begin
          n_fail++; $display("FAIL b2b bit%0d: Tx=%b, required %b", k, tx_at[k*CPB+5], exp_bit);
        end
      end
    end
    ndone = 0;
    for (int i = 2; i <= 2*N + 1; i++) if (done_at[i] === 1'b1) ndone++;
    n_checks++; if (ndone != 2 || done_at[N] !== 1'b1 || done_at[2*N] !== 1'b1) begin n_fail++; $display("FAIL b2b tx_done: pulses=%0d, required 2 at cycles %0d and %0d", ndone, N, 2*N); end
    n_checks++; if (busy_at[N+1] !== 1'b1 || busy_at[2*N] !== 1'b1 || busy_at[2*N+1] !== 1'b0) begin n_fail++; $display("FAIL b2b busy: %b%b%b, required 110", busy_at[N+1], busy_at[2*N], busy_at[2*N+1]); end
    $display("test_back_to_back bytes=3c,c3 tx_done_pulses=%0d", ndone);
  endtask

  task automatic test_enable_abort();
    bit ok;
    int bad;
    wait_ready(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort ready_timeout: data_ready=%b, required 1", data_ready); end
    data_in    = 8'h92;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_in = 8'h69;
    @(posedge clk);
    #1 data_valid = 1'b0;
    observe(2, 37);
    n_checks++; if (tx_at[37] !== 1'b0 || busy_at[37] !== 1'b1 || rdy_at[37] !== 1'b0) begin n_fail++; $display("FAIL abort pre: Tx=%b busy=%b ready=%b, required 0 1 0", tx_at[37], busy_at[37], rdy_at[37]); end
    enable = 1'b0;
    observe(38, 38);
    n_checks++; if (tx_at[38] !== 1'b1)   begin n_fail++; $display("FAIL abort tx: Tx=%b, required 1", tx_at[38]); end
    n_checks++; if (busy_at[38] !== 1'b0) begin n_fail++; $display("FAIL abort busy: busy=%b, required 0", busy_at[38]); end
    n_checks++; if (done_at[38] !== 1'b0) begin n_fail++; $display("FAIL abort done: tx_done=%b, required 0", done_at[38]); end
    n_checks++; if (rdy_at[38] !== 1'b1)  begin n_fail++; $display("FAIL abort ready: data_ready=%b, required 1", rdy_at[38]); end
    observe(39, 43);
    enable = 1'b1;
    observe(44, 80);
    bad = 0;
    for (int i = 39; i <= 80; i++)
      if (tx_at[i] !== 1'b1 || busy_at[i] !== 1'b0 || done_at[i] !== 1'b0) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL abort no_resume: %0d active cycles, required 0", bad); end
    $display("test_enable_abort idle_violations=%0d", bad);
    test_frame(8'h5A, "after_enable");
  endtask

  task automatic test_reset_midstream();
    bit ok;
    int bad;
    wait_ready(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rst ready_timeout: data_ready=%b, required 1", data_ready); end
    data_in    = 8'hF0;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    observe(1, 23);
    n_checks++; if (tx_at[23] !== 1'b0 || busy_at[23] !== 1'b1) begin n_fail++; $display("FAIL rst pre: Tx=%b busy=%b, required 0 1", tx_at[23], busy_at[23]); end
    #2 nRst = 1'b0;
    #1;
    n_checks++; if (Tx !== 1'b1)         begin n_fail++; $display("FAIL rst tx: Tx=%b, required 1", Tx); end
    n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL rst ready: data_ready=%b, required 1", data_ready); end
    n_checks++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rst busy: busy=%b, required 0", busy); end
    n_checks++; if (tx_done !== 1'b0)    begin n_fail++; $display("FAIL rst done: tx_done=%b, required 0", tx_done); end
    repeat (2) @(negedge clk);
    nRst = 1'b1;
    observe(1, 30);
    bad = 0;
    for (int i = 1; i <= 30; i++)
      if (tx_at[i] !== 1'b1 || busy_at[i] !== 1'b0 || done_at[i] !== 1'b0) bad++;
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rst no_resume: %0d active cycles, required 0", bad); end
    $display("test_reset_midstream idle_violations=%0d", bad);
  endtask

  initial begin
    test_power_on_reset();
    test_frame(8'hA5, "a5");
    test_frame(8'h01, "01");
    test_frame(8'hFF, "ff");
    test_back_to_back();
    test_enable_abort();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
